// File: rtl/condition_unit_pkg.sv
// condition_unit_pkg
// Shared constants for the condition unit: condition-code encodings, the bit
// positions of N/Z/C/V inside a 4-bit flag word, the two-state FSM encoding
// and a helper that merges a flag update under a 2-bit field mask.
package condition_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    // mask[1] selects the N,Z field and mask[0] selects the C,V field.
    function automatic logic [3:0] merge_flags(input logic [3:0] base,
                                               input logic [3:0] upd,
                                               input logic [1:0] mask);
        logic [3:0] res;
        res = base;
        if (mask[1]) begin
            res[FLAG_N] = upd[FLAG_N];
            res[FLAG_Z] = upd[FLAG_Z];
        end
        if (mask[0]) begin
            res[FLAG_C] = upd[FLAG_C];
            res[FLAG_V] = upd[FLAG_V];
        end
        return res;
    endfunction

endpackage

// File: rtl/condition_unit_cond_check.sv
// cond_check
// Purely combinational condition-code decode.
// Ports:
//   cond  - 4-bit condition field
//   flags - {N,Z,C,V} flags to test against
//   pass  - high when the condition holds
module cond_check
    import condition_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    // Decode the condition against the individual flag bits.
    always_comb begin
        n    = flags[FLAG_N];
        z    = flags[FLAG_Z];
        c    = flags[FLAG_C];
        v    = flags[FLAG_V];
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/condition_unit.sv
// condition_unit
// Gates the decoder's write enables by the instruction's condition, holds an
// ALU flag update for one cycle before committing it, and counts squashed
// instructions (saturating).
// Optional feature macro: FLAG_BYPASS_EN. When defined, a pending flag update
// is forwarded into condition evaluation so the unit never stalls; when
// undefined, a conditional instruction right behind a flag write stalls one
// cycle.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   inp_valid / out_ready      - instruction handshake
//   inp_cond                   - condition field
//   inp_flag_write             - bit1 updates N,Z; bit0 updates C,V
//   inp_reg_write/mem_write/pc_src - ungated enables
//   inp_alu_flags              - {N,Z,C,V} from the ALU
//   out_reg_write/mem_write/pc_src - gated enables
//   out_cond_ex                - condition passed
//   out_flags                  - committed {N,Z,C,V}
//   out_carry                  - carry for the ALU
//   out_squash_count           - squashed-instruction count
module condition_unit
    import condition_unit_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inp_valid,
    output logic             out_ready,
    input  logic [3:0]       inp_cond,
    input  logic [1:0]       inp_flag_write,
    input  logic             inp_reg_write,
    input  logic             inp_mem_write,
    input  logic             inp_pc_src,
    input  logic [3:0]       inp_alu_flags,
    output logic             out_reg_write,
    output logic             out_mem_write,
    output logic             out_pc_src,
    output logic             out_cond_ex,
    output logic [3:0]       out_flags,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_squash_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state, next_state;
    logic [3:0] pending_flags;
    logic [1:0] pending_mask;
    logic [3:0] eval_flags;
    logic       accept;
    logic       capture;
    logic       cond_pass;

    cond_check u_cond_check (
        .cond  (inp_cond),
        .flags (eval_flags),
        .pass  (cond_pass)
    );

    // State register: PEND means a flag update is waiting to commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Evaluation flags, handshake, enable gating and next state.
    always_comb begin
        eval_flags = out_flags;
        out_ready  = 1'b1;
`ifdef FLAG_BYPASS_EN
        if (state == ST_PEND) begin
            eval_flags = merge_flags(out_flags, pending_flags, pending_mask);
        end
`else
        // Only AL may pass while the committed flags are one write stale.
        if ((state == ST_PEND) && inp_valid && (inp_cond != COND_AL)) begin
            out_ready = 1'b0;
        end
`endif
        out_cond_ex   = cond_pass;
        out_carry     = eval_flags[FLAG_C];
        accept        = inp_valid && out_ready;
        capture       = accept && cond_pass && (|inp_flag_write);
        out_reg_write = accept && cond_pass && inp_reg_write;
        out_mem_write = accept && cond_pass && inp_mem_write;
        out_pc_src    = accept && cond_pass && inp_pc_src;
        next_state    = capture ? ST_PEND : ST_IDLE;
    end

    // Flag pipeline and squash counter. A commit of the old pending value and
    // a capture of a new one may happen on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_flags        <= 4'b0000;
            pending_flags    <= 4'b0000;
            pending_mask     <= 2'b00;
            out_squash_count <= '0;
        end else begin
            if (state == ST_PEND) begin
                out_flags <= merge_flags(out_flags, pending_flags, pending_mask);
            end
            if (capture) begin
                pending_flags <= inp_alu_flags;
                pending_mask  <= inp_flag_write;
            end
            if (accept && !cond_pass && (out_squash_count != CNT_MAX)) begin
                out_squash_count <= out_squash_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_condition_unit.sv
// tb_condition_unit
// Randomised and directed stimulus for condition_unit. The reference model
// keeps the list of accepted flag writes with their cycle stamps: committed
// flags include writes at least two cycles old, forwarded flags include the
// previous cycle's write. Expected responses are queued by the stimulus and
// checked by an independent monitor on the falling edge.
module tb_condition_unit;

`ifdef FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    localparam int MAXCNT = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inp_valid = 1'b0;
    logic       out_ready;
    logic [3:0] inp_cond = 4'b0;
    logic [1:0] inp_flag_write = 2'b0;
    logic       inp_reg_write = 1'b0;
    logic       inp_mem_write = 1'b0;
    logic       inp_pc_src = 1'b0;
    logic [3:0] inp_alu_flags = 4'b0;
    logic       out_reg_write, out_mem_write, out_pc_src, out_cond_ex, out_carry;
    logic [3:0] out_flags;
    logic [7:0] out_squash_count;

    condition_unit #(.CNT_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .inp_valid        (inp_valid),
        .out_ready        (out_ready),
        .inp_cond         (inp_cond),
        .inp_flag_write   (inp_flag_write),
        .inp_reg_write    (inp_reg_write),
        .inp_mem_write    (inp_mem_write),
        .inp_pc_src       (inp_pc_src),
        .inp_alu_flags    (inp_alu_flags),
        .out_reg_write    (out_reg_write),
        .out_mem_write    (out_mem_write),
        .out_pc_src       (out_pc_src),
        .out_cond_ex      (out_cond_ex),
        .out_flags        (out_flags),
        .out_carry        (out_carry),
        .out_squash_count (out_squash_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ready;
        logic       reg_w;
        logic       mem_w;
        logic       pc_s;
        logic       cond_ex;
        logic       carry;
        logic [3:0] flags;
        logic [7:0] count;
    } resp_t;

    typedef struct {
        int         cyc;
        logic [3:0] flags;
        logic [1:0] mask;
    } write_t;

    resp_t      exp_q[$];
    write_t     writes[$];
    logic [3:0] base_flags = 4'b0;
    int         cyc = 0;
    int         n_squash = 0;
    int         total = 0;
    int         bad = 0;

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] overlay(input logic [3:0] f, input logic [3:0] nf,
                                           input logic [1:0] m);
        logic [3:0] r;
        r = f;
        if (m[1]) r[3:2] = nf[3:2];
        if (m[0]) r[1:0] = nf[1:0];
        return r;
    endfunction

    function automatic logic [3:0] flags_upto(input int last);
        logic [3:0] r;
        r = base_flags;
        foreach (writes[i]) begin
            if (writes[i].cyc <= last) r = overlay(r, writes[i].flags, writes[i].mask);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one expected response per presented instruction.
    always @(negedge clk) begin
        resp_t r;
        if (!reset && inp_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL scoreboard: got no expected entry, required one (cycle %0d)", cyc);
            end else begin
                r = exp_q.pop_front();
                checkOutput("out_ready", {7'b0, out_ready}, {7'b0, r.ready});
                checkOutput("out_reg_write", {7'b0, out_reg_write}, {7'b0, r.reg_w});
                checkOutput("out_mem_write", {7'b0, out_mem_write}, {7'b0, r.mem_w});
                checkOutput("out_pc_src", {7'b0, out_pc_src}, {7'b0, r.pc_s});
                checkOutput("out_cond_ex", {7'b0, out_cond_ex}, {7'b0, r.cond_ex});
                checkOutput("out_carry", {7'b0, out_carry}, {7'b0, r.carry});
                checkOutput("out_flags", {4'b0, out_flags}, {4'b0, r.flags});
                checkOutput("out_squash_count", out_squash_count, r.count);
            end
        end
    end

    // Presents one instruction (or one idle cycle when v=0) and holds it
    // until the model says it has been accepted.
    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [1:0] fw,
                                 input logic rw, input logic mw, input logic pc,
                                 input logic [3:0] alu);
        bit         accepted;
        bit         stall;
        int         tries;
        logic       cx;
        logic [3:0] committed, eval;
        resp_t      r;
        tries          = 0;
        inp_valid      = v;
        inp_cond       = c;
        inp_flag_write = fw;
        inp_reg_write  = rw;
        inp_mem_write  = mw;
        inp_pc_src     = pc;
        inp_alu_flags  = alu;
        do begin
            while (writes.size() > 0 && writes[0].cyc <= cyc - 2) begin
                base_flags = overlay(base_flags, writes[0].flags, writes[0].mask);
                void'(writes.pop_front());
            end
            committed = flags_upto(cyc - 2);
            eval      = BYPASS ? flags_upto(cyc - 1) : committed;
            stall     = !BYPASS && v && (c != 4'b1110) && (writes.size() > 0)
                        && (writes[writes.size()-1].cyc == cyc - 1);
            cx        = cond_holds(c, eval);
            accepted  = v && !stall;
            if (v) begin
                r.ready   = !stall;
                r.reg_w   = accepted && cx && rw;
                r.mem_w   = accepted && cx && mw;
                r.pc_s    = accepted && cx && pc;
                r.cond_ex = cx;
                r.carry   = eval[1];
                r.flags   = committed;
                r.count   = 8'((n_squash > MAXCNT) ? MAXCNT : n_squash);
                exp_q.push_back(r);
            end
            if (accepted && cx && (fw != 2'b00)) writes.push_back('{cyc, alu, fw});
            if (accepted && !cx) n_squash++;
            @(posedge clk);
            #1;
            cyc++;
            tries++;
        end while (v && !accepted && tries < 4);
        inp_valid = 1'b0;
    endtask

    task automatic doReset(input int n);
        reset         = 1'b1;
        inp_valid     = 1'($urandom_range(0, 1));
        inp_cond      = 4'b1110;
        inp_reg_write = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        reset      = 1'b0;
        inp_valid  = 1'b0;
        writes.delete();
        base_flags = 4'b0;
        n_squash   = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        doReset(2);

        // Unconditional instruction straight after reset.
        applyStimulus(1, 4'b1110, 2'b00, 1, 0, 0, 4'b0000);
        // Full flag write, two idle cycles, then EQ sees Z.
        applyStimulus(1, 4'b1110, 2'b11, 0, 0, 0, 4'b0100);
        applyStimulus(0, 4'b0000, 2'b00, 0, 0, 0, 4'b0000);
        applyStimulus(0, 4'b0000, 2'b00, 0, 0, 0, 4'b0000);
        applyStimulus(1, 4'b0000, 2'b00, 1, 1, 0, 4'b0000);
        // C,V-only write over committed 0100 leaves N,Z alone.
        applyStimulus(1, 4'b1110, 2'b01, 0, 0, 0, 4'b1111);
        applyStimulus(0, 4'b0000, 2'b00, 0, 0, 0, 4'b0000);
        applyStimulus(0, 4'b0000, 2'b00, 0, 0, 0, 4'b0000);
        applyStimulus(1, 4'b0010, 2'b00, 0, 0, 1, 4'b0000);
        // Back-to-back flag write then EQ.
        applyStimulus(1, 4'b1110, 2'b11, 0, 0, 0, 4'b0100);
        applyStimulus(1, 4'b0000, 2'b00, 1, 0, 0, 4'b0000);
        applyStimulus(1, 4'b0001, 2'b00, 1, 0, 0, 4'b0000);
        // Reset while a flag write is pending.
        applyStimulus(1, 4'b1110, 2'b11, 0, 0, 0, 4'b1010);
        doReset(1);
        applyStimulus(1, 4'b0000, 2'b00, 1, 0, 0, 4'b0000);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                doReset(1);
            end else if ($urandom_range(0, 3) == 0) begin
                applyStimulus(0, 4'b0000, 2'b00, 0, 0, 0, 4'b0000);
            end else begin
                applyStimulus(1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end
        end

        // Squash counter saturation.
        doReset(1);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 4'b1111, 2'($urandom_range(0, 3)), 1, 1, 1,
                          4'($urandom_range(0, 15)));
        end
        checkOutput("squash_saturated", out_squash_count, 8'hFF);
        applyStimulus(1, 4'b1110, 2'b00, 1, 0, 0, 4'b0000);

        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/condition_unit.md
CONDITION_UNIT -- requirements
Module: condition_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the squash counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port inp_valid, input, 1, decoded instruction present.
REQ-005 SHALL have port out_ready, output, 1, instruction accepted this cycle when high together with inp_valid.
REQ-006 SHALL have port inp_cond, input, 4, condition field.
REQ-007 SHALL have port inp_flag_write, input, 2: bit1 updates N,Z; bit0 updates C,V.
REQ-008 SHALL have ports inp_reg_write, inp_mem_write and inp_pc_src, each input, 1, ungated decoder enables.
REQ-009 SHALL have port inp_alu_flags, input, 4, {N,Z,C,V} produced by the ALU for this instruction.
REQ-010 SHALL have ports out_reg_write, out_mem_write and out_pc_src, each output, 1, the gated enables.
REQ-011 SHALL have port out_cond_ex, output, 1, condition passed.
REQ-012 SHALL have port out_flags, output, 4, committed {N,Z,C,V}.
REQ-013 SHALL have port out_carry, output, 1, carry fed to the ALU inp_carry.
REQ-014 SHALL have port out_squash_count, output, CNT_W, count of squashed instructions.

Function
REQ-015 SHALL define accept as inp_valid && out_ready.
REQ-016 SHALL evaluate out_cond_ex combinationally from the evaluation flags: EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V; HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V); AL 1110 1; 1111 0.
REQ-017 SHALL drive each gated enable as accept && out_cond_ex && the matching inp_* enable, in the same cycle as accept.
REQ-018 SHALL capture pending_flags, pending_mask and pending_valid=1 on accept with out_cond_ex && |inp_flag_write; otherwise pending_valid SHALL be 0 at the next edge.
REQ-019 SHALL commit pending_flags into out_flags on the edge after capture, applying them field-wise under pending_mask; fields not selected are unchanged.
REQ-020 SHALL, when a commit and a new capture fall on the same edge, commit the old pending value and hold the new value as pending.
REQ-021 SHALL implement two states: IDLE (pending_valid=0) and PEND (pending_valid=1); IDLE->PEND on a capture; PEND->IDLE on an edge with no new capture; PEND->PEND on an edge with a new capture.
REQ-022 SHALL increment out_squash_count on each accept with out_cond_ex=0 and saturate at 2^CNT_W-1.
REQ-023 SHALL drive out_carry as the C bit of the evaluation flags.
REQ-024 SHALL hold out_ready=1 in IDLE.

Reset
REQ-025 SHALL, on reset, clear out_flags, pending_flags, pending_mask, pending_valid and out_squash_count to 0 and enter IDLE.
REQ-026 SHALL give reset priority over accept; an instruction presented in a reset cycle is dropped, and a pending write is discarded.

Configuration
REQ-027 SHALL, with FLAG_BYPASS_EN defined, set the evaluation flags to out_flags overlaid by pending_flags under pending_mask when in PEND, and keep out_ready=1 always.
REQ-028 SHALL, without FLAG_BYPASS_EN, use out_flags as the evaluation flags and drive out_ready=0 in PEND when inp_valid && inp_cond!=1110; this stall lasts exactly one cycle.

Structure
REQ-029 SHALL take the condition-code constants, the flag bit indices (N=3, Z=2, C=1, V=0) and the state encoding from the shared package.
REQ-030 SHALL place the combinational decode from REQ-016 in a sub-module cond_check (inputs cond and flags; output pass).

Verification
REQ-031 SHALL cover: reset, then cond=1110, reg_write=1 -> out_reg_write=1, out_flags=0000, squash count=0.
REQ-032 SHALL cover: accept flag_write=11 with alu_flags=0100, then 2 idle cycles, then cond=0000 -> cond_ex=1, out_flags=0100.
REQ-033 SHALL cover: flag_write=01 with alu_flags=1111 over committed 0100 -> out_flags=0111 after commit.
REQ-034 SHALL cover: a back-to-back flag-write (alu 0100) followed by cond=0000 -> with FLAG_BYPASS_EN: no stall, cond_ex=1; without it: out_ready=0 for 1 cycle, then cond_ex=1.
REQ-035 SHALL cover: 300 accepts with cond=1111, CNT_W=8 -> count=255, all gated enables 0.
REQ-036 SHALL cover: reset asserted while in PEND -> next cycle out_flags=0000, IDLE, out_ready=1.
